vfpu_normalize: RTL and testbench

- Post-arithmetic normalization and rounding stage of the VFPU datapath.
- Consumes the pre-normalized sign/exponent/mantissa triple produced by the adder stage, qualified by that stage's done_o.
- Normalizes, rounds to nearest-even, handles overflow/underflow/zero, and emits a packed IEEE-754 binary32 result.
- Output uses a valid/ready handshake toward the streamer/result register.

---
 rtl/vfpu_normalize_pkg.sv | 25 ++
 rtl/vfpu_lzc.sv | 20 ++
 rtl/vfpu_normalize.sv | 186 ++++++++++++++++++
 tb/tb_vfpu_normalize.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vfpu_normalize_pkg.sv
// Shared constants and types for the VFPU normalize/round stage.
package vfpu_normalize_pkg;

    localparam int FP_EXP_WIDTH          = 8;
    localparam int FP_MANT_WIDTH         = 23;
    localparam int FP_EXP_PRENORM_WIDTH  = 10;
    localparam int FP_MANT_PRENORM_WIDTH = 28;
    localparam int FP_BIAS               = 127;
    localparam int FP_EXP_MAX            = 255;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        OUT
    } vfpu_norm_state_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
        logic zr;
    } vfpu_flags_t;

endpackage

// File: rtl/vfpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module vfpu_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan upward so the most significant set bit has the final say.
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/vfpu_normalize.sv
// Normalize + round-to-nearest-even stage producing a packed binary32 result.
// Define VFPU_NORM_FLAGS_EN to add the registered {OF,UF,NX,ZR} flags_o port.
module vfpu_normalize
    import vfpu_normalize_pkg::*;
#(
    parameter int EXP_W   = FP_EXP_WIDTH,
    parameter int MANT_W  = FP_MANT_WIDTH,
    parameter int PEXP_W  = FP_EXP_PRENORM_WIDTH,
    parameter int PMANT_W = FP_MANT_PRENORM_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      signPreNorm_i,
    input  logic [PEXP_W-1:0]         exponentPreNorm_i,
    input  logic [PMANT_W-1:0]        mantissaPreNorm_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [EXP_W+MANT_W:0]     result_o,
    output logic                      valid_o,
    input  logic                      ready_i
`ifdef VFPU_NORM_FLAGS_EN
    ,
    output logic [3:0]                flags_o
`endif
);

    localparam int RES_W = EXP_W + MANT_W + 1;
    localparam int LZC_W = $clog2(PMANT_W + 1);
    localparam int SIG_W = MANT_W + 2;

    localparam logic signed [PEXP_W:0] EXP_ZERO_S = '0;
    localparam logic signed [PEXP_W:0] EXP_MAX_S  = (PEXP_W + 1)'(FP_EXP_MAX);

    vfpu_norm_state_t state_q, state_d;

    logic                     sign_q, sign_d;
    logic signed [PEXP_W:0]   exp_q, exp_d;
    logic [PMANT_W-1:0]       mant_q, mant_d;
    logic                     zero_q, zero_d;
    logic [RES_W-1:0]         result_q, result_d;

    logic [LZC_W-1:0]         lzc;
    logic [LZC_W-1:0]         lzc_m1;
    logic                     accept;
    logic [SIG_W-1:0]         sig_r;
    logic                     carry_r;
    logic [MANT_W-1:0]        frac_r;
    logic signed [PEXP_W:0]   exp_r;

`ifdef VFPU_NORM_FLAGS_EN
    vfpu_flags_t              flags_q, flags_d;
    logic                     nx_r;
`endif

    // Rounded significand covering the hidden bit up to the carry position.
    function automatic logic [SIG_W-1:0] rne_sig(input logic [PMANT_W-1:0] m);
        logic inc;
        inc = m[2] & (m[3] | (|m[1:0]));
        return m[PMANT_W-1:3] + SIG_W'(inc);
    endfunction

    function automatic logic [RES_W-1:0] sat_pack(input logic                   s,
                                                  input logic signed [PEXP_W:0] e,
                                                  input logic [MANT_W-1:0]      f,
                                                  input logic                   z);
        if (z || (e <= EXP_ZERO_S)) begin
            return {s, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        end else if (e >= EXP_MAX_S) begin
            return {s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else begin
            return {s, e[EXP_W-1:0], f};
        end
    endfunction

    vfpu_lzc #(
        .WIDTH (PMANT_W)
    ) u_lzc (
        .data_i (mant_q),
        .cnt_o  (lzc)
    );

    assign lzc_m1 = lzc - LZC_W'(1);
    assign accept = valid_i & ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
`ifdef VFPU_NORM_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifdef VFPU_NORM_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    // Working operand registers are always overwritten before use.
    always_ff @(posedge clk_i) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        mant_q <= mant_d;
        zero_q <= zero_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = NORM;
            NORM:                 state_d = ROUND;
            ROUND:                state_d = OUT;
            OUT:     if (ready_i) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == IDLE) & ~rst_i;
        valid_o  = (state_q == OUT);
        result_o = result_q;
`ifdef VFPU_NORM_FLAGS_EN
        flags_o  = flags_q;
`endif
    end

    always_comb begin
        sig_r   = rne_sig(mant_q);
        carry_r = sig_r[SIG_W-1];
        frac_r  = carry_r ? sig_r[MANT_W:1] : sig_r[MANT_W-1:0];
        exp_r   = exp_q + $signed({{PEXP_W{1'b0}}, carry_r});
`ifdef VFPU_NORM_FLAGS_EN
        nx_r    = mant_q[2] | (|mant_q[1:0]);
`endif
    end

    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        zero_d   = zero_q;
        result_d = result_q;
`ifdef VFPU_NORM_FLAGS_EN
        flags_d  = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d = signPreNorm_i;
                    exp_d  = {exponentPreNorm_i[PEXP_W-1], exponentPreNorm_i};
                    mant_d = mantissaPreNorm_i;
                    zero_d = 1'b0;
                end
            end
            NORM: begin
                zero_d = (mant_q == '0);
                if (mant_q[PMANT_W-1]) begin
                    // The bit shifted out still contributes to sticky.
                    mant_d = {1'b0, mant_q[PMANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + $signed({{PEXP_W{1'b0}}, 1'b1});
                end else if (mant_q != '0) begin
                    mant_d = mant_q << lzc_m1;
                    exp_d  = exp_q - $signed({{(PEXP_W + 1 - LZC_W){1'b0}}, lzc_m1});
                end
            end
            ROUND: begin
                result_d = sat_pack(sign_q, exp_r, frac_r, zero_q);
`ifdef VFPU_NORM_FLAGS_EN
                if (zero_q) begin
                    flags_d = '{of: 1'b0, uf: 1'b0, nx: 1'b0, zr: 1'b1};
                end else if (exp_r <= EXP_ZERO_S) begin
                    flags_d = '{of: 1'b0, uf: 1'b1, nx: 1'b1, zr: 1'b1};
                end else if (exp_r >= EXP_MAX_S) begin
                    flags_d = '{of: 1'b1, uf: 1'b0, nx: 1'b1, zr: 1'b0};
                end else begin
                    flags_d = '{of: 1'b0, uf: 1'b0, nx: nx_r, zr: 1'b0};
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vfpu_normalize.sv
// Directed-vector bench for vfpu_normalize with hand-computed binary32 results.
module tb_vfpu_normalize;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        signPreNorm_i;
    logic [9:0]  exponentPreNorm_i;
    logic [27:0] mantissaPreNorm_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] result_o;
    logic        valid_o;
    logic        ready_i;
`ifdef VFPU_NORM_FLAGS_EN
    logic [3:0]  flags_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vfpu_normalize dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .signPreNorm_i     (signPreNorm_i),
        .exponentPreNorm_i (exponentPreNorm_i),
        .mantissaPreNorm_i (mantissaPreNorm_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .result_o          (result_o),
        .valid_o           (valid_o),
        .ready_i           (ready_i)
`ifdef VFPU_NORM_FLAGS_EN
        ,
        .flags_o           (flags_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
        end
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, {31'b0, ready_o}, 32'd1);
        signPreNorm_i     = s;
        exponentPreNorm_i = e;
        mantissaPreNorm_i = m;
        valid_i           = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic run_op(input logic s, input logic [9:0] e, input logic [27:0] m,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg,
                          input string tag);
        send(s, e, m, tag);
        check({tag, "_busy"}, {31'b0, ready_o}, 32'd0);
        check({tag, "_v1"}, {31'b0, valid_o}, 32'd0);
        @(posedge clk);
        #1 check({tag, "_v2"}, {31'b0, valid_o}, 32'd0);
        @(posedge clk);
        #1 check({tag, "_v3"}, {31'b0, valid_o}, 32'd1);
        check({tag, "_res"}, result_o, exp_res);
`ifdef VFPU_NORM_FLAGS_EN
        check({tag, "_flg"}, {28'b0, flags_o}, {28'b0, exp_flg});
`endif
        @(posedge clk);
        #1 check({tag, "_idle"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i             = 1'b1;
        valid_i           = 1'b0;
        ready_i           = 1'b1;
        signPreNorm_i     = 1'b0;
        exponentPreNorm_i = '0;
        mantissaPreNorm_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'h0);
`ifdef VFPU_NORM_FLAGS_EN
        check("rst_flags", {28'b0, flags_o}, 32'h0);
`endif
        @(negedge clk);
        rst_i = 1'b0;
        #1 check("post_rst_ready", {31'b0, ready_o}, 32'd1);

        run_op(1'b0, 10'd127, 28'h4000000, 32'h3F800000, 4'b0000, "one");
        run_op(1'b0, 10'd127, 28'h8000000, 32'h40000000, 4'b0000, "two");
        run_op(1'b0, 10'd130, 28'h0800000, 32'h3F800000, 4'b0000, "lshift3");
        run_op(1'b1, 10'd127, 28'h4000000, 32'hBF800000, 4'b0000, "neg_one");
        run_op(1'b0, 10'd127, 28'h4000004, 32'h3F800000, 4'b0010, "tie_even");
        run_op(1'b0, 10'd127, 28'h400000C, 32'h3F800002, 4'b0010, "tie_odd");
        run_op(1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 4'b0010, "rnd_carry");
        run_op(1'b0, 10'd127, 28'h8000003, 32'h40000000, 4'b0010, "rsh_sticky");
        run_op(1'b0, 10'd127, 28'h800000C, 32'h40000001, 4'b0010, "rsh_round");
        run_op(1'b0, 10'd254, 28'h4000000, 32'h7F000000, 4'b0000, "max_norm");
        run_op(1'b0, 10'd254, 28'h8000000, 32'h7F800000, 4'b1010, "ovf_shift");
        run_op(1'b1, 10'd254, 28'h7FFFFFC, 32'hFF800000, 4'b1010, "ovf_round");
        run_op(1'b0, 10'd255, 28'h4000000, 32'h7F800000, 4'b1010, "ovf_exp255");
        run_op(1'b1, 10'd0,   28'h4000000, 32'h80000000, 4'b0111, "uf_exp0");
        run_op(1'b0, 10'h3FB, 28'h4000000, 32'h00000000, 4'b0111, "uf_negexp");
        run_op(1'b0, 10'd2,   28'h0800000, 32'h00000000, 4'b0111, "uf_lshift");
        run_op(1'b0, 10'd127, 28'h0000000, 32'h00000000, 4'b0001, "zero");
        run_op(1'b1, 10'd0,   28'h0000000, 32'h80000000, 4'b0001, "zero_prio");

        ready_i = 1'b0;
        send(1'b0, 10'd127, 28'h4000000, "bp");
        @(posedge clk);
        @(posedge clk);
        #1 check("bp_valid0", {31'b0, valid_o}, 32'd1);
        signPreNorm_i     = 1'b1;
        exponentPreNorm_i = 10'd200;
        mantissaPreNorm_i = 28'h6000000;
        valid_i           = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'b0, valid_o}, 32'd1);
            check("bp_result", result_o, 32'h3F800000);
            check("bp_ready", {31'b0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {31'b0, ready_o}, 32'd1);
        check("bp_release_valid", {31'b0, valid_o}, 32'd0);

        send(1'b0, 10'd130, 28'h0800000, "mid_rst");
        @(posedge clk);
        #1 rst_i = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        check("mid_rst_ready", {31'b0, ready_o}, 32'd0);
        check("mid_rst_result", result_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        #1 check("mid_rst_idle", {31'b0, ready_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("mid_rst_no_valid", {31'b0, valid_o}, 32'd0);
        end
        run_op(1'b1, 10'd128, 28'h6000000, 32'hC0400000, 4'b0000, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
